// File: rtl/jtlt_sched_pkg.sv
// Shared constants and helpers for the JTL-T toggle scheduler.
// Holds the timing-derived HOLDOFF default and the scheduler state encoding.
package jtlt_sched_pkg;

    localparam real CT_PS  = 20.1;
    localparam real CLK_PS = 4.5;

    // Integer femtosecond copies of the reals above, so the ceiling stays an integer constant.
    localparam int CT_FS  = 20100;
    localparam int CLK_FS = 4500;

    localparam int HOLDOFF_DEFAULT = (CT_FS + CLK_FS - 1) / CLK_FS;
    localparam int N_REQ_DEFAULT   = 4;
    localparam int CNT_W_DEFAULT   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_ISSUE = 2'd2
    } sched_state_e;

    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/jtlt_rr_pick.sv
// Round-robin picker: first set bit of i_mask at or above i_ptr, wrapping.
// The mask is doubled so a single forward scan covers the wrap-around.
module jtlt_rr_pick
    import jtlt_sched_pkg::*;
#(
    parameter int N = N_REQ_DEFAULT
) (
    input  logic [N-1:0]       i_mask,
    input  logic [id_w(N)-1:0] i_ptr,
    output logic               o_any,
    output logic [id_w(N)-1:0] o_winner
);

    localparam int ID_W = id_w(N);

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_sel;
    int             w_idx;
    int             w_sum;

    assign w_dbl = {i_mask, i_mask};
    assign w_sel = w_dbl[i_ptr +: N];
    assign o_any = |i_mask;

    always_comb begin
        w_idx = 0;
        for (int j = N - 1; j >= 0; j--) begin
            if (w_sel[j]) begin
                w_idx = j;
            end
        end
        w_sum = int'(i_ptr) + w_idx;
        if (w_sum >= N) begin
            w_sum = w_sum - N;
        end
        o_winner = ID_W'(w_sum);
    end

endmodule

// File: rtl/jtlt_toggle_scheduler.sv
// Shares one toggle-encoded JTL-T line among N_REQ requesters: per-requester
// pending counters, round-robin grant, and a HOLDOFF-cycle gap between line edges.
module jtlt_toggle_scheduler
    import jtlt_sched_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT,
    parameter int HOLDOFF = HOLDOFF_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic                   ovf_clr,
    output logic                   a_tgl,
    output logic                   grant_vld,
    output logic [id_w(N_REQ)-1:0] grant_id,
    output logic [N_REQ-1:0]       ovf,
    output logic                   busy
);

    localparam int                ID_W     = id_w(N_REQ);
    localparam int                HOLD_W   = id_w(HOLDOFF) + 1;
    localparam logic [HOLD_W-1:0] HOLD_RST = HOLD_W'(HOLDOFF - 1);
    localparam logic [CNT_W-1:0]  PEND_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0]  r_pend [N_REQ];
    logic [HOLD_W-1:0] r_hold;
    logic [ID_W-1:0]   r_rr_ptr;
    logic              r_a_tgl;
    logic              r_grant_vld;
    logic [ID_W-1:0]   r_grant_id;
    logic [N_REQ-1:0]  r_ovf;

    logic [N_REQ-1:0]  w_nz;
    logic              w_any;
    logic [ID_W-1:0]   w_winner;
    logic              w_issue;
    sched_state_e      w_state;
    logic [CNT_W-1:0]  w_pend_nxt [N_REQ];
    logic [N_REQ-1:0]  w_drop;
    logic [ID_W-1:0]   w_rr_nxt;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            w_nz[i] = |r_pend[i];
        end
    end

    jtlt_rr_pick #(
        .N (N_REQ)
    ) u_pick (
        .i_mask   (w_nz),
        .i_ptr    (r_rr_ptr),
        .o_any    (w_any),
        .o_winner (w_winner)
    );

    // Scheduler state is fully implied by the hold timer and the pending mask.
    always_comb begin
        if (r_hold != '0) begin
            w_state = ST_HOLD;
        end else if (w_any) begin
            w_state = ST_ISSUE;
        end else begin
            w_state = ST_IDLE;
        end
    end

    assign w_issue  = (w_state == ST_ISSUE);
    assign w_rr_nxt = (w_winner == ID_W'(N_REQ - 1)) ? '0 : w_winner + ID_W'(1);

    // A request arriving on a saturated counter is dropped unless the same edge drains it.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            w_drop[i]     = 1'b0;
            w_pend_nxt[i] = r_pend[i];
            if (req[i] && !(w_issue && (w_winner == ID_W'(i)))) begin
                if (r_pend[i] == PEND_MAX) begin
                    w_drop[i] = 1'b1;
                end else begin
                    w_pend_nxt[i] = r_pend[i] + CNT_W'(1);
                end
            end else if (!req[i] && w_issue && (w_winner == ID_W'(i))) begin
                w_pend_nxt[i] = r_pend[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                r_pend[i] <= '0;
            end
            r_hold      <= HOLD_RST;
            r_rr_ptr    <= '0;
            r_a_tgl     <= 1'b0;
            r_grant_vld <= 1'b0;
            r_grant_id  <= '0;
            r_ovf       <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                r_pend[i] <= w_pend_nxt[i];
            end
            r_ovf <= (ovf_clr ? '0 : r_ovf) | w_drop;
            if (w_issue) begin
                r_a_tgl     <= ~r_a_tgl;
                r_grant_vld <= 1'b1;
                r_grant_id  <= w_winner;
                r_hold      <= HOLD_RST;
                r_rr_ptr    <= w_rr_nxt;
            end else begin
                r_grant_vld <= 1'b0;
                if (r_hold != '0) begin
                    r_hold <= r_hold - HOLD_W'(1);
                end
            end
        end
    end

    assign a_tgl     = r_a_tgl;
    assign grant_vld = r_grant_vld;
    assign grant_id  = r_grant_id;
    assign ovf       = r_ovf;
    assign busy      = (w_state != ST_IDLE);

endmodule
